// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder_if
// Description : Instruction-fetch bus between the CPU fetch stage and the
//               imem_responder. The CPU is the master, the responder the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_responder_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] imem_addr;
  logic            imem_ren;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_raddr_handshake;
  logic            imem_rdata_handshake;

  modport master (
    output imem_addr,
    output imem_ren,
    input  imem_rdata,
    input  imem_raddr_handshake,
    input  imem_rdata_handshake
  );

  modport slave (
    input  imem_addr,
    input  imem_ren,
    output imem_rdata,
    output imem_raddr_handshake,
    output imem_rdata_handshake
  );
endinterface
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Fixed-latency instruction memory responder. Accepts one fetch
//               at a time, waits LATENCY cycles, reads a synchronous SRAM and
//               returns the word with a one-cycle data handshake. The last
//               returned word is held on imem_rdata between fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  wire logic                           ACLK,
  input  wire logic                           ARESETn,
  imem_responder_if.slave                     imem,
  output logic                                stall_o,
  output logic                                sram_cen,
  output logic [$clog2(DEPTH_WORDS)-1:0]      sram_addr,
  input  wire logic [XLEN-1:0]                sram_rdata
);

  localparam int         AW          = $clog2(DEPTH_WORDS);
  localparam logic [3:0] C_WAIT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_hold;
  logic [AW-1:0]   r_idx;

  logic [AW-1:0]   w_idx;
  logic            w_accept;
  logic            w_unused;

  // Word index: byte offset and bits above the SRAM size are dropped, so
  // out-of-range addresses wrap modulo DEPTH_WORDS.
  assign w_idx    = imem.imem_addr[AW+1:2];
  assign w_unused = ^{imem.imem_addr[XLEN-1:AW+2], imem.imem_addr[1:0]};

  // A new address can be taken when no fetch is outstanding (IDLE) or when
  // the outstanding one completes this cycle (DATA). Gated by reset so the
  // handshake stays low while ARESETn is asserted.
  assign w_accept = ARESETn & imem.imem_ren &
                    ((r_state == S_IDLE) | (r_state == S_DATA));

  // Fetch sequencer: latch address, count down the wait, capture data.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_hold  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (imem.imem_ren) begin
            r_idx   <= w_idx;
            r_cnt   <= C_WAIT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Address/ren changes here are ignored; the fetch always completes.
          if (r_cnt == 4'd0) begin
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DATA: begin
          r_hold <= sram_rdata;
          if (imem.imem_ren) begin
            r_idx   <= w_idx;
            r_cnt   <= C_WAIT_INIT;
            r_state <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from state; reset forces state to IDLE and the
  // hold register to zero, giving the required reset output values.
  assign imem.imem_raddr_handshake = w_accept;
  assign imem.imem_rdata_handshake = (r_state == S_DATA);
  assign imem.imem_rdata           = (r_state == S_DATA) ? sram_rdata : r_hold;
  assign stall_o                   = (r_state != S_DATA);
  assign sram_cen                  = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign sram_addr                 = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_responder
// Description : Self-checking bench for imem_responder: directed cycle table,
//               latency sweep on LATENCY=1/15 instances, and randomized
//               traffic against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

  localparam int XLEN  = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LAT   = 2;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b1;

  always #5 ACLK = ~ACLK;

  logic [31:0] mem [0:DEPTH-1];

  // ---------------- main instance (LATENCY=2) ----------------
  imem_responder_if #(.XLEN(XLEN)) bus ();
  logic          stall, cen;
  logic [AW-1:0] saddr;
  logic [31:0]   srd;

  imem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .imem(bus), .stall_o(stall),
    .sram_cen(cen), .sram_addr(saddr), .sram_rdata(srd)
  );

  // Synchronous SRAM: data valid the cycle after the enable.
  always @(posedge ACLK) if (cen) srd <= mem[saddr];

  // ---------------- sweep instances (LATENCY=1 and 15) ----------------
  imem_responder_if #(.XLEN(XLEN)) bus1 ();
  imem_responder_if #(.XLEN(XLEN)) bus15 ();
  logic          stall1, cen1, stall15, cen15;
  logic [AW-1:0] saddr1, saddr15;
  logic [31:0]   srd1, srd15;

  imem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .ACLK(ACLK), .ARESETn(ARESETn), .imem(bus1), .stall_o(stall1),
    .sram_cen(cen1), .sram_addr(saddr1), .sram_rdata(srd1)
  );
  imem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(15)) dut15 (
    .ACLK(ACLK), .ARESETn(ARESETn), .imem(bus15), .stall_o(stall15),
    .sram_cen(cen15), .sram_addr(saddr15), .sram_rdata(srd15)
  );

  always @(posedge ACLK) if (cen1)  srd1  <= mem[saddr1];
  always @(posedge ACLK) if (cen15) srd15 <= mem[saddr15];

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // One record = one clock cycle: inputs, optional SRAM preload, expectations.
  typedef struct {
    logic          rst_n;
    logic          ren;
    logic [31:0]   addr;
    logic          wr;
    logic [AW-1:0] widx;
    logic [31:0]   wdat;
    logic          acc;
    logic          rhs;
    logic          cen;
    logic [AW-1:0] sa;
    logic [31:0]   rd;
    logic          st;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic rst_n, input logic ren, input logic [31:0] addr,
                   input logic wr, input int widx, input logic [31:0] wdat,
                   input logic acc, input logic rhs, input logic c,
                   input int sa, input logic [31:0] rd, input logic st);
    vec_t r;
    r.rst_n = rst_n; r.ren = ren; r.addr = addr;
    r.wr = wr; r.widx = AW'(widx); r.wdat = wdat;
    r.acc = acc; r.rhs = rhs; r.cen = c; r.sa = AW'(sa); r.rd = rd; r.st = st;
    vq.push_back(r);
  endtask

  // Compare all observable outputs of the main instance against expectations.
  task automatic chk_all(input string nm, input int i, input logic acc,
                         input logic rhs, input logic c, input logic [AW-1:0] sa,
                         input logic [31:0] rd, input logic st);
    chk({nm, ".raddr_hs"}, i, 32'(bus.imem_raddr_handshake), 32'(acc));
    chk({nm, ".rdata_hs"}, i, 32'(bus.imem_rdata_handshake), 32'(rhs));
    chk({nm, ".sram_cen"}, i, 32'(cen), 32'(c));
    chk({nm, ".sram_addr"}, i, 32'(saddr), 32'(sa));
    chk({nm, ".rdata"}, i, bus.imem_rdata, rd);
    chk({nm, ".stall"}, i, 32'(stall), 32'(st));
  endtask

  // Reference model state (transaction level).
  int          m_cyc;
  bit          m_busy;
  int          m_data_cyc;
  logic [31:0] m_last;
  logic [AW-1:0] m_idx;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    bus.imem_ren = 1'b0;  bus.imem_addr = '0;
    bus1.imem_ren = 1'b0; bus1.imem_addr = '0;
    bus15.imem_ren = 1'b0; bus15.imem_addr = '0;

    // ---- directed table ----
    //  rst ren addr      wr idx dat     acc rhs cen sa rdata   stall
    // reset held, ren=1 must not leak through
    v(0, 1, 32'h0,     0, 0, 0,      0, 0, 0, 0, 32'h0,  1);
    v(0, 0, 32'h0,     0, 0, 0,      0, 0, 0, 0, 32'h0,  1);
    // single fetch, first edge after release
    v(1, 1, 32'h0,     1, 0, 32'h13, 1, 0, 0, 0, 32'h0,  1);
    v(1, 0, 32'h0,     0, 0, 0,      0, 0, 0, 0, 32'h0,  1);
    v(1, 0, 32'h0,     0, 0, 0,      0, 0, 1, 0, 32'h0,  1);
    v(1, 0, 32'h0,     0, 0, 0,      0, 1, 0, 0, 32'h13, 0);
    v(1, 0, 32'h0,     0, 0, 0,      0, 0, 0, 0, 32'h13, 1);
    // back-to-back fetches of 0x0, 0x4, 0x8
    v(1, 1, 32'h0,     1, 0, 32'hA,  1, 0, 0, 0, 32'h13, 1);
    v(1, 1, 32'h4,     1, 1, 32'hB,  0, 0, 0, 0, 32'h13, 1);
    v(1, 1, 32'h4,     1, 2, 32'hC,  0, 0, 1, 0, 32'h13, 1);
    v(1, 1, 32'h4,     0, 0, 0,      1, 1, 0, 0, 32'hA,  0);
    v(1, 1, 32'h8,     0, 0, 0,      0, 0, 0, 1, 32'hA,  1);
    v(1, 1, 32'h8,     0, 0, 0,      0, 0, 1, 1, 32'hA,  1);
    v(1, 1, 32'h8,     0, 0, 0,      1, 1, 0, 1, 32'hB,  0);
    v(1, 0, 32'h8,     0, 0, 0,      0, 0, 0, 2, 32'hB,  1);
    v(1, 0, 32'h8,     0, 0, 0,      0, 0, 1, 2, 32'hB,  1);
    v(1, 0, 32'h8,     0, 0, 0,      0, 1, 0, 2, 32'hC,  0);
    v(1, 0, 32'h8,     0, 0, 0,      0, 0, 0, 2, 32'hC,  1);
    // wrapped address, then ren dropped and address changed during WAIT
    v(1, 1, 32'h1006,  0, 0, 0,      1, 0, 0, 2, 32'hC,  1);
    v(1, 0, 32'h40,    0, 0, 0,      0, 0, 0, 1, 32'hC,  1);
    v(1, 0, 32'h40,    0, 0, 0,      0, 0, 1, 1, 32'hC,  1);
    v(1, 0, 32'h40,    0, 0, 0,      0, 1, 0, 1, 32'hB,  0);
    v(1, 0, 32'h40,    0, 0, 0,      0, 0, 0, 1, 32'hB,  1);
    v(1, 0, 32'h40,    0, 0, 0,      0, 0, 0, 1, 32'hB,  1);
    // reset pulse during WAIT abandons the fetch; next fetch is normal
    v(1, 1, 32'h8,     0, 0, 0,      1, 0, 0, 1, 32'hB,  1);
    v(0, 1, 32'h8,     0, 0, 0,      0, 0, 0, 0, 32'h0,  1);
    v(1, 0, 32'h8,     0, 0, 0,      0, 0, 0, 0, 32'h0,  1);
    v(1, 0, 32'h8,     0, 0, 0,      0, 0, 0, 0, 32'h0,  1);
    v(1, 1, 32'h8,     0, 0, 0,      1, 0, 0, 0, 32'h0,  1);
    v(1, 0, 32'h0,     0, 0, 0,      0, 0, 0, 2, 32'h0,  1);
    v(1, 0, 32'h0,     0, 0, 0,      0, 0, 1, 2, 32'h0,  1);
    v(1, 0, 32'h0,     0, 0, 0,      0, 1, 0, 2, 32'hC,  0);
    v(1, 0, 32'h0,     0, 0, 0,      0, 0, 0, 2, 32'hC,  1);

    #2 ARESETn = 1'b0;
    @(posedge ACLK); #1;
    for (int i = 0; i < vq.size(); i++) begin
      ARESETn      = vq[i].rst_n;
      bus.imem_ren  = vq[i].ren;
      bus.imem_addr = vq[i].addr;
      if (vq[i].wr) mem[vq[i].widx] = vq[i].wdat;
      @(negedge ACLK);
      chk_all("vec", i, vq[i].acc, vq[i].rhs, vq[i].cen, vq[i].sa, vq[i].rd, vq[i].st);
      @(posedge ACLK); #1;
    end
    bus.imem_ren = 1'b0;

    // ---- latency sweep: single fetch on LATENCY=1 and LATENCY=15 ----
    begin
      int d1, d15;
      d1 = -1; d15 = -1;
      bus1.imem_ren = 1'b1;  bus1.imem_addr = 32'h1C;
      bus15.imem_ren = 1'b1; bus15.imem_addr = 32'h20;
      @(negedge ACLK);
      chk("sweep1.accept", 0, 32'(bus1.imem_raddr_handshake), 32'd1);
      chk("sweep15.accept", 0, 32'(bus15.imem_raddr_handshake), 32'd1);
      @(posedge ACLK); #1;
      bus1.imem_ren = 1'b0; bus15.imem_ren = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge ACLK);
        if (bus1.imem_rdata_handshake && d1 < 0) begin
          d1 = c;
          chk("sweep1.data", c, bus1.imem_rdata, mem[7]);
        end
        if (bus15.imem_rdata_handshake && d15 < 0) begin
          d15 = c;
          chk("sweep15.data", c, bus15.imem_rdata, mem[8]);
        end
        @(posedge ACLK); #1;
      end
      chk("sweep1.distance", 0, 32'(d1), 32'd2);
      chk("sweep15.distance", 0, 32'(d15), 32'd16);
    end

    // ---- randomized traffic vs. transaction-level model ----
    m_cyc = 0; m_busy = 0; m_data_cyc = 0; m_last = '0; m_idx = '0;
    for (int n = 0; n < 2000; n++) begin
      bit is_data, free, e_acc;
      ARESETn       = (n == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      bus.imem_ren  = ($urandom_range(0, 3) != 0);
      bus.imem_addr = $urandom;
      @(negedge ACLK);
      if (!ARESETn) begin
        is_data = 0; e_acc = 0;
        chk_all("rst", n, 1'b0, 1'b0, 1'b0, '0, 32'h0, 1'b1);
      end else begin
        is_data = m_busy && (m_cyc == m_data_cyc);
        free    = !m_busy || is_data;
        e_acc   = bus.imem_ren && free;
        chk_all("rnd", n, e_acc, is_data,
                m_busy && (m_cyc == m_data_cyc - 1), m_idx,
                is_data ? mem[m_idx] : m_last, !is_data);
      end
      @(posedge ACLK);
      if (!ARESETn) begin
        m_busy = 0; m_last = '0; m_idx = '0;
      end else begin
        if (is_data) begin
          m_last = mem[m_idx];
          m_busy = 0;
        end
        if (e_acc) begin
          m_busy     = 1;
          m_data_cyc = m_cyc + LAT + 1;
          m_idx      = bus.imem_addr[AW+1:2];
        end
      end
      m_cyc++;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter XLEN, default 32, shall set the data and address width.
REQ-002 Parameter DEPTH_WORDS, default 1024, shall set the backing SRAM size in 32-bit words; it is always a power of 2.
REQ-003 Parameter LATENCY, default 2, range 1..15, shall set the number of WAIT cycles between address accept and data return.
REQ-004 ACLK  in  1  the single clock; all state shall update on its rising edge.
REQ-005 ARESETn  in  1  asynchronous, active-low reset.
REQ-006 imem_addr  in  XLEN  fetch byte address from the CPU.
REQ-007 imem_ren  in  1  fetch request; the CPU may hold it high continuously.
REQ-008 imem_rdata  out  XLEN  instruction word returned to the CPU.
REQ-009 imem_raddr_handshake  out  1  one-cycle pulse marking the cycle in which imem_addr is accepted.
REQ-010 imem_rdata_handshake  out  1  one-cycle pulse marking the cycle in which imem_rdata is valid.
REQ-011 stall_o  out  1  fetch-pending indication, intended for global_stall_en.
REQ-012 sram_cen  out  1  synchronous-SRAM read enable.
REQ-013 sram_addr  out  log2(DEPTH_WORDS)  SRAM word address.
REQ-014 sram_rdata  in  XLEN  SRAM read data, valid in the cycle after sram_cen=1.

Function
REQ-015 The FSM shall have exactly three states: IDLE, WAIT and DATA.
REQ-016 IDLE: imem_raddr_handshake shall equal imem_ren; when imem_ren=1, the block shall latch the address and go to WAIT with the wait counter set to LATENCY-1.
REQ-017 IDLE: when imem_ren=0, the block shall stay in IDLE.
REQ-018 The latched word index shall be imem_addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] and all upper bits shall be ignored, so out-of-range addresses wrap modulo DEPTH_WORDS.
REQ-019 WAIT: the counter shall decrement each cycle; sram_cen=1 and sram_addr=latched index only in the cycle where the counter equals 0; that cycle shall transition to DATA.
REQ-020 sram_cen shall be 0 in every other cycle, and sram_addr shall hold the latched index.
REQ-021 DATA: imem_rdata_handshake=1, imem_rdata=sram_rdata (combinational pass-through), and the hold register shall load sram_rdata at the end of the cycle.
REQ-022 Outside DATA, imem_rdata shall equal the hold register, so the last word persists.
REQ-023 DATA with imem_ren=1: the block shall accept a new address in the same cycle (imem_raddr_handshake=1) and go to WAIT, giving back-to-back throughput of one word per LATENCY+1 cycles.
REQ-024 DATA with imem_ren=0: the block shall return to IDLE.
REQ-025 Latency: an address accepted in cycle T shall return data in cycle T+LATENCY+1.
REQ-026 stall_o shall be 1 in IDLE and WAIT, and 0 in DATA.
REQ-027 imem_addr changes while in WAIT shall be ignored; only the accept-cycle value is used.
REQ-028 imem_ren deasserting during WAIT shall not abort the fetch; the DATA cycle shall still occur.
REQ-029 At most one fetch shall be outstanding; imem_raddr_handshake shall never be 1 in WAIT.

Reset
REQ-030 While ARESETn=0: state=IDLE, counter=0, hold register=0, latched index=0.
REQ-031 While ARESETn=0: imem_raddr_handshake=0, imem_rdata_handshake=0, sram_cen=0, imem_rdata=0 and stall_o=1, independent of imem_ren.
REQ-032 Reset asserted mid-fetch shall abandon the fetch: no imem_rdata_handshake for that fetch, even after reset release.
REQ-033 The first accept shall be possible in the first rising edge after ARESETn rises with imem_ren=1.

Verification
REQ-034 LATENCY=2, SRAM[0]=0x00000013, imem_ren=1, imem_addr=0x0 after reset -> raddr_handshake in cycle 0, sram_cen in cycle 2 with sram_addr=0, rdata_handshake with imem_rdata=0x00000013 in cycle 3.
REQ-035 Continuous imem_ren=1, addresses 0x0, 0x4, 0x8 holding 0xA, 0xB, 0xC -> rdata_handshake every 3 cycles, data in order 0xA, 0xB, 0xC, no gap between DATA and the next accept.
REQ-036 DEPTH_WORDS=1024, imem_addr=0x00001006 -> sram_addr=0x001 (wrap, low bits dropped).
REQ-037 imem_ren dropped to 0 and imem_addr changed to 0x40 during WAIT -> data for the original address still returned, then IDLE, and imem_rdata holds that word afterwards.
REQ-038 ARESETn pulsed low during WAIT -> no rdata_handshake; imem_rdata=0 and stall_o=1 during reset; the next fetch completes normally.
REQ-039 LATENCY=1 and LATENCY=15 sweeps -> measured accept-to-data distance = 2 and 16 cycles respectively.
